ram4k_arbiter: RTL and testbench

- Two-requester access controller for the 4K x 16 single-port RAM, which has chip enable, write/read strobes, a 12-bit address and separate din/dout.
- Serialises requests from two independent masters and drives the RAM control, address and data pins from registers.
- Returns read data with a one-cycle completion pulse.
- Sits between the RAM4K instance and the two bus masters, for example a CPU port and a loader/DMA port.

---
 rtl/ram4k_arbiter_if.sv | 39 +++
 rtl/ram4k_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ram4k_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram4k_arbiter_if.sv
// Bundle of the two requester ports and the RAM4K pin group for ram4k_arbiter.
// The slave modport is the arbiter's view; master is everything around it.
interface ram4k_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] adr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvld0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] adr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvld1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          mem_e;
    logic          mem_w;
    logic          mem_r;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  req0, we0, adr0, wdata0, req1, we1, adr1, wdata1, mem_dout,
        output gnt0, rvld0, gnt1, rvld1, rdata, busy,
               mem_e, mem_w, mem_r, mem_adr, mem_din
    );

    modport master (
        output req0, we0, adr0, wdata0, req1, we1, adr1, wdata1, mem_dout,
        input  gnt0, rvld0, gnt1, rvld1, rdata, busy,
               mem_e, mem_w, mem_r, mem_adr, mem_din
    );
endinterface

// File: rtl/ram4k_arbiter.sv
// Two-requester access controller for the 4K x 16 single-port RAM; all RAM pins registered.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module ram4k_arbiter #(
    parameter int AW     = 12,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    ram4k_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [1:0] WAIT_INIT = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    state_t        r_state, w_state_nxt;
    logic          r_sel, w_sel_nxt;
    logic [1:0]    r_cnt, w_cnt_nxt;
    logic          r_gnt0, w_gnt0_nxt, r_gnt1, w_gnt1_nxt;
    logic          r_rvld0, w_rvld0_nxt, r_rvld1, w_rvld1_nxt;
    logic [DW-1:0] r_rdata, w_rdata_nxt;
    logic          r_mem_e, w_mem_e_nxt, r_mem_w, w_mem_w_nxt, r_mem_r, w_mem_r_nxt;
    logic [AW-1:0] r_mem_adr, w_mem_adr_nxt;
    logic [DW-1:0] r_mem_din, w_mem_din_nxt;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic          r_rr, w_rr_nxt;
`endif

    logic          w_any, w_pick, w_pick_we, w_done_rd, w_clr;
    logic [AW-1:0] w_pick_adr;
    logic [DW-1:0] w_pick_din;

    always_comb begin
        w_any = bus.req0 | bus.req1;
`ifdef RAM_ARB_FIXED_PRIO_EN
        w_pick = ~bus.req0;
`else
        // On a tie the requester other than the pointer wins.
        w_pick = (bus.req0 && bus.req1) ? ~r_rr : ~bus.req0;
`endif
        w_pick_we  = w_pick ? bus.we1    : bus.we0;
        w_pick_adr = w_pick ? bus.adr1   : bus.adr0;
        w_pick_din = w_pick ? bus.wdata1 : bus.wdata0;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_cnt_nxt     = r_cnt;
        w_rdata_nxt   = r_rdata;
        w_gnt0_nxt    = 1'b0;
        w_gnt1_nxt    = 1'b0;
        w_rvld0_nxt   = 1'b0;
        w_rvld1_nxt   = 1'b0;
        w_mem_e_nxt   = r_mem_e;
        w_mem_w_nxt   = r_mem_w;
        w_mem_r_nxt   = r_mem_r;
        w_mem_adr_nxt = r_mem_adr;
        w_mem_din_nxt = r_mem_din;
        w_done_rd     = 1'b0;
        w_clr         = 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
        w_rr_nxt      = r_rr;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_sel_nxt     = w_pick;
`ifndef RAM_ARB_FIXED_PRIO_EN
                    if (bus.req0 && bus.req1) w_rr_nxt = w_pick;
`endif
                    w_mem_e_nxt   = 1'b1;
                    w_mem_w_nxt   = w_pick_we;
                    w_mem_r_nxt   = ~w_pick_we;
                    w_mem_adr_nxt = w_pick_adr;
                    w_mem_din_nxt = w_pick_din;
                    // Write completion pulse lands in the ACCESS cycle itself.
                    w_gnt0_nxt    = w_pick_we & ~w_pick;
                    w_gnt1_nxt    = w_pick_we & w_pick;
                    w_state_nxt   = ACCESS;
                end else begin
                    w_clr = 1'b1;
                end
            end
            ACCESS: begin
                if (r_mem_w) begin
                    w_clr       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (RD_LAT > 1) begin
                    w_cnt_nxt   = WAIT_INIT;
                    w_state_nxt = WAIT;
                end else begin
                    w_done_rd = 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt == 2'd0) w_done_rd = 1'b1;
                else               w_cnt_nxt = r_cnt - 2'd1;
            end
            RESP: w_state_nxt = IDLE;
        endcase

        if (w_done_rd) begin
            w_rdata_nxt = bus.mem_dout;
            w_gnt0_nxt  = ~r_sel;
            w_rvld0_nxt = ~r_sel;
            w_gnt1_nxt  = r_sel;
            w_rvld1_nxt = r_sel;
            w_clr       = 1'b1;
            w_state_nxt = RESP;
        end
        if (w_clr) begin
            w_mem_e_nxt   = 1'b0;
            w_mem_w_nxt   = 1'b0;
            w_mem_r_nxt   = 1'b0;
            w_mem_adr_nxt = '0;
            w_mem_din_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= 1'b0;
            r_cnt     <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvld0   <= 1'b0;
            r_rvld1   <= 1'b0;
            r_rdata   <= '0;
            r_mem_e   <= 1'b0;
            r_mem_w   <= 1'b0;
            r_mem_r   <= 1'b0;
            r_mem_adr <= '0;
            r_mem_din <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            r_rr      <= 1'b1;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt0    <= w_gnt0_nxt;
            r_gnt1    <= w_gnt1_nxt;
            r_rvld0   <= w_rvld0_nxt;
            r_rvld1   <= w_rvld1_nxt;
            r_rdata   <= w_rdata_nxt;
            r_mem_e   <= w_mem_e_nxt;
            r_mem_w   <= w_mem_w_nxt;
            r_mem_r   <= w_mem_r_nxt;
            r_mem_adr <= w_mem_adr_nxt;
            r_mem_din <= w_mem_din_nxt;
`ifndef RAM_ARB_FIXED_PRIO_EN
            r_rr      <= w_rr_nxt;
`endif
        end
    end

    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.rvld0   = r_rvld0;
    assign bus.rvld1   = r_rvld1;
    assign bus.rdata   = r_rdata;
    assign bus.busy    = (r_state != IDLE);
    assign bus.mem_e   = r_mem_e;
    assign bus.mem_w   = r_mem_w;
    assign bus.mem_r   = r_mem_r;
    assign bus.mem_adr = r_mem_adr;
    assign bus.mem_din = r_mem_din;
endmodule

// File: tb/tb_ram4k_arbiter.sv
// Self-checking bench for ram4k_arbiter: RD_LAT=1 and RD_LAT=3 instances, each with a RAM model.
// Expected grants and read data come from a transaction-level arbitration/memory model.
module tb_ram4k_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram4k_arbiter_if #(.AW(AW), .DW(DW)) ifa();
    ram4k_arbiter_if #(.AW(AW), .DW(DW)) ifb();

    ram4k_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(ifa));
    ram4k_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(ifb));

    // RAM for RD_LAT=1: data valid within the strobe cycle.
    logic [15:0] ram1 [0:4095];
    always @(posedge clk) if (ifa.mem_e && ifa.mem_w) ram1[ifa.mem_adr] <= ifa.mem_din;
    assign ifa.mem_dout = ifa.mem_r ? ram1[ifa.mem_adr] : 16'h0000;

    // RAM for RD_LAT=3: two extra pipeline stages.
    logic [15:0] ram3 [0:4095];
    logic [15:0] p1, p2;
    always @(posedge clk) begin
        if (ifb.mem_e && ifb.mem_w) ram3[ifb.mem_adr] <= ifb.mem_din;
        p1 <= ifb.mem_r ? ram3[ifb.mem_adr] : 16'h0000;
        p2 <= p1;
    end
    assign ifb.mem_dout = p2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] mm [0:4095];
    bit m_rr;

    int          ev_who[$];
    int          ev_cyc[$];
    bit          ev_rv[$];
    logic [15:0] ev_rd[$];
    logic [30:0] ev_bus[$];
    int v_both, v_proto, r_cycles, w_cycles, t_start;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Tie-break rule of the arbiter, applied at transaction level.
    function automatic int tie_pick();
`ifdef RAM_ARB_FIXED_PRIO_EN
        return 0;
`else
        int p;
        p = (m_rr == 1'b1) ? 0 : 1;
        m_rr = p[0];
        return p;
`endif
    endfunction

    // Drives requester 0/1 on the RD_LAT=1 instance and records every grant event.
    task automatic serve(input int c0, input int c1,
                         input bit w0, input logic [11:0] a0, input logic [15:0] d0,
                         input bit w1, input logic [11:0] a1, input logic [15:0] d1,
                         input int budget);
        ev_who.delete(); ev_cyc.delete(); ev_rv.delete(); ev_rd.delete(); ev_bus.delete();
        v_both = 0; v_proto = 0; r_cycles = 0; w_cycles = 0;
        ifa.we0 = w0; ifa.adr0 = a0; ifa.wdata0 = d0;
        ifa.we1 = w1; ifa.adr1 = a1; ifa.wdata1 = d1;
        ifa.req0 = (c0 > 0);
        ifa.req1 = (c1 > 0);
        t_start = cyc;
        for (int k = 0; k < budget && (c0 > 0 || c1 > 0); k++) begin
            tick();
            if (ifa.gnt0 && ifa.gnt1) v_both++;
            if ((ifa.mem_w && ifa.mem_r) || ((ifa.mem_w || ifa.mem_r) && !ifa.mem_e) ||
                (ifa.rvld0 && !ifa.gnt0) || (ifa.rvld1 && !ifa.gnt1)) v_proto++;
            if (ifa.mem_r) r_cycles++;
            if (ifa.mem_w) w_cycles++;
            if (ifa.gnt0) begin
                ev_who.push_back(0); ev_cyc.push_back(cyc); ev_rv.push_back(ifa.rvld0);
                ev_rd.push_back(ifa.rdata);
                ev_bus.push_back({ifa.mem_e, ifa.mem_w, ifa.mem_r, ifa.mem_adr, ifa.mem_din});
                c0--;
                if (c0 == 0) ifa.req0 = 1'b0;
            end
            if (ifa.gnt1) begin
                ev_who.push_back(1); ev_cyc.push_back(cyc); ev_rv.push_back(ifa.rvld1);
                ev_rd.push_back(ifa.rdata);
                ev_bus.push_back({ifa.mem_e, ifa.mem_w, ifa.mem_r, ifa.mem_adr, ifa.mem_din});
                c1--;
                if (c1 == 0) ifa.req1 = 1'b0;
            end
        end
        ifa.req0 = 1'b0;
        ifa.req1 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [75:0] va, vb;
        repeat (3) tick();
        va = {ifa.gnt0, ifa.gnt1, ifa.rvld0, ifa.rvld1, ifa.busy, ifa.mem_e, ifa.mem_w,
              ifa.mem_r, ifa.mem_adr, ifa.mem_din, ifa.rdata};
        vb = {ifb.gnt0, ifb.gnt1, ifb.rvld0, ifb.rvld1, ifb.busy, ifb.mem_e, ifb.mem_w,
              ifb.mem_r, ifb.mem_adr, ifb.mem_din, ifb.rdata};
        n_tests++;
        if (va !== '0) begin n_fail++; $display("FAIL reset_outputs_lat1: got %h want 0", va); end
        n_tests++;
        if (vb !== '0) begin n_fail++; $display("FAIL reset_outputs_lat3: got %h want 0", vb); end
        rst = 1'b0;
        m_rr = 1'b1;
        tick();
        n_tests++;
        if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %b want 0", ifa.busy); end
    endtask

    task automatic test_write();
        serve(1, 0, 1'b1, 12'h123, 16'hBEEF, 1'b0, 12'h000, 16'h0000, 10);
        mm[12'h123] = 16'hBEEF;
        n_tests++;
        if (ev_who.size() !== 1 || ev_who[0] !== 0) begin
            n_fail++; $display("FAIL write_grant: %0d grants want one to requester 0", ev_who.size());
        end
        n_tests++;
        if (ev_cyc[0] - t_start + 1 !== 2) begin
            n_fail++; $display("FAIL write_latency: got %0d want 2", ev_cyc[0] - t_start + 1);
        end
        n_tests++;
        if (ev_bus[0] !== {1'b1, 1'b1, 1'b0, 12'h123, 16'hBEEF}) begin
            n_fail++; $display("FAIL write_pins: got %h want %h", ev_bus[0], {3'b110, 12'h123, 16'hBEEF});
        end
        n_tests++;
        if (w_cycles !== 1 || ev_rv[0] !== 1'b0 || v_proto !== 0) begin
            n_fail++; $display("FAIL write_strobe: wcyc %0d rv %b proto %0d want 1 0 0", w_cycles, ev_rv[0], v_proto);
        end
    endtask

    task automatic test_read();
        serve(0, 1, 1'b0, 12'h000, 16'h0000, 1'b0, 12'h123, 16'h0000, 10);
        n_tests++;
        if (ev_who.size() !== 1 || ev_who[0] !== 1) begin
            n_fail++; $display("FAIL read_grant: %0d grants want one to requester 1", ev_who.size());
        end
        n_tests++;
        if (ev_cyc[0] - t_start + 1 !== 3) begin
            n_fail++; $display("FAIL read_latency: got %0d want 3", ev_cyc[0] - t_start + 1);
        end
        n_tests++;
        if (ev_rv[0] !== 1'b1 || ev_rd[0] !== mm[12'h123]) begin
            n_fail++; $display("FAIL read_data: rv %b data %h want 1 %h", ev_rv[0], ev_rd[0], mm[12'h123]);
        end
        n_tests++;
        if (r_cycles !== 1) begin n_fail++; $display("FAIL read_strobe_len: got %0d want 1", r_cycles); end
    endtask

    task automatic test_round_robin();
        int exp[$];
        int c0, c1, p;
        c0 = 3; c1 = 3;
        while (c0 > 0 || c1 > 0) begin
            if (c0 > 0 && c1 > 0) p = tie_pick();
            else p = (c0 > 0) ? 0 : 1;
            exp.push_back(p);
            if (p == 0) c0--; else c1--;
        end
        serve(3, 3, 1'b1, 12'h010, 16'hA5A5, 1'b1, 12'h011, 16'h5A5A, 40);
        mm[12'h010] = 16'hA5A5;
        mm[12'h011] = 16'h5A5A;
        n_tests++;
        if (ev_who.size() !== 6) begin n_fail++; $display("FAIL rr_count: got %0d want 6", ev_who.size()); end
        for (int i = 0; i < 6 && i < ev_who.size(); i++) begin
            n_tests++;
            if (ev_who[i] !== exp[i]) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, ev_who[i], exp[i]);
            end
        end
        n_tests++;
        if (v_both !== 0 || v_proto !== 0) begin
            n_fail++; $display("FAIL rr_exclusive: both %0d proto %0d want 0 0", v_both, v_proto);
        end
    endtask

    task automatic test_reset_mid();
        int bad, p;
        ifa.req0 = 1'b1; ifa.we0 = 1'b0; ifa.adr0 = 12'h123;
        tick();
        n_tests++;
        if ((ifa.mem_e && ifa.mem_r) !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_access: e %b r %b want 1 1", ifa.mem_e, ifa.mem_r);
        end
        rst = 1'b1;
        ifa.req0 = 1'b0;
        tick();
        n_tests++;
        if ({ifa.mem_e, ifa.mem_r, ifa.mem_w, ifa.gnt0, ifa.gnt1, ifa.rvld0, ifa.rvld1, ifa.busy} !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_abandon: e %b r %b g0 %b v0 %b busy %b want all 0",
                               ifa.mem_e, ifa.mem_r, ifa.gnt0, ifa.rvld0, ifa.busy);
        end
        rst = 1'b0;
        m_rr = 1'b1;
        bad = 0;
        repeat (3) begin
            tick();
            if (ifa.gnt0 || ifa.gnt1 || ifa.rvld0 || ifa.rvld1 || ifa.mem_e) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL rstmid_no_gnt: got %0d events want 0", bad); end
        p = tie_pick();
        serve(1, 1, 1'b1, 12'h020, 16'h1111, 1'b1, 12'h021, 16'h2222, 20);
        mm[12'h020] = 16'h1111;
        mm[12'h021] = 16'h2222;
        n_tests++;
        if (ev_who.size() !== 2 || ev_who[0] !== p) begin
            n_fail++; $display("FAIL rstmid_tie: %0d grants first %0d want 2 first %0d", ev_who.size(), ev_who[0], p);
        end
    endtask

    task automatic test_boundary();
        serve(1, 0, 1'b1, 12'h000, 16'h0001, 1'b0, 12'h000, 16'h0000, 10);
        mm[12'h000] = 16'h0001;
        serve(0, 1, 1'b0, 12'h000, 16'h0000, 1'b1, 12'hFFF, 16'hFFFF, 10);
        mm[12'hFFF] = 16'hFFFF;
        n_tests++;
        if (ev_bus[0] !== {3'b110, 12'hFFF, 16'hFFFF}) begin
            n_fail++; $display("FAIL bound_pins_fff: got %h want %h", ev_bus[0], {3'b110, 12'hFFF, 16'hFFFF});
        end
        serve(1, 0, 1'b0, 12'h000, 16'h0000, 1'b0, 12'h000, 16'h0000, 10);
        n_tests++;
        if (ev_rd[0] !== mm[12'h000] || ev_rv[0] !== 1'b1) begin
            n_fail++; $display("FAIL bound_read_000: got %h rv %b want %h 1", ev_rd[0], ev_rv[0], mm[12'h000]);
        end
        serve(0, 1, 1'b0, 12'h000, 16'h0000, 1'b0, 12'hFFF, 16'h0000, 10);
        n_tests++;
        if (ev_rd[0] !== mm[12'hFFF] || ev_rv[0] !== 1'b1) begin
            n_fail++; $display("FAIL bound_read_fff: got %h rv %b want %h 1", ev_rd[0], ev_rv[0], mm[12'hFFF]);
        end
    endtask

    task automatic test_rdlat3();
        int t, g, rc;
        logic [15:0] rd;
        logic rv;
        ifb.req1 = 1'b1; ifb.we1 = 1'b1; ifb.adr1 = 12'h055; ifb.wdata1 = 16'h1234;
        t = cyc; g = -100;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ifb.gnt1) begin g = cyc; ifb.req1 = 1'b0; break; end
        end
        ifb.req1 = 1'b0;
        tick();
        n_tests++;
        if (g - t + 1 !== 2) begin n_fail++; $display("FAIL lat3_write_latency: got %0d want 2", g - t + 1); end
        ifb.req1 = 1'b1; ifb.we1 = 1'b0;
        t = cyc; g = -100; rc = 0; rd = '0; rv = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (ifb.mem_r) rc++;
            if (ifb.gnt1) begin g = cyc; rd = ifb.rdata; rv = ifb.rvld1; ifb.req1 = 1'b0; break; end
        end
        ifb.req1 = 1'b0;
        tick();
        n_tests++;
        if (rc !== 3) begin n_fail++; $display("FAIL lat3_strobe_len: got %0d want 3", rc); end
        n_tests++;
        if (g - t + 1 !== 5) begin n_fail++; $display("FAIL lat3_read_latency: got %0d want 5", g - t + 1); end
        n_tests++;
        if (rd !== 16'h1234 || rv !== 1'b1) begin
            n_fail++; $display("FAIL lat3_read_data: got %h rv %b want 1234 1", rd, rv);
        end
    endtask

    task automatic test_random();
        logic [11:0] pool [8] = '{12'h000, 12'hFFF, 12'h123, 12'h010, 12'h011, 12'h200, 12'h201, 12'h7FF};
        logic [15:0] d;
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            serve(1, 0, 1'b1, pool[i], d, 1'b0, 12'h000, 16'h0000, 10);
            mm[pool[i]] = d;
        end
        for (int it = 0; it < 24; it++) begin
            int mode, c0, c1, first;
            bit w0, w1;
            logic [11:0] a0, a1;
            logic [15:0] d0, d1;
            int e_who[$];
            bit e_rv[$];
            logic [15:0] e_rd[$];
            mode = $urandom_range(0, 2);
            c0 = (mode != 1) ? 1 : 0;
            c1 = (mode != 0) ? 1 : 0;
            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            a0 = pool[$urandom_range(0, 7)]; a1 = pool[$urandom_range(0, 7)];
            d0 = 16'($urandom); d1 = 16'($urandom);
            first = (c0 > 0 && c1 > 0) ? tie_pick() : ((c0 > 0) ? 0 : 1);
            for (int j = 0; j < c0 + c1; j++) begin
                int who;
                who = (j == 0) ? first : 1 - first;
                e_who.push_back(who);
                if (who == 0) begin
                    e_rv.push_back(!w0); e_rd.push_back(mm[a0]);
                    if (w0) mm[a0] = d0;
                end else begin
                    e_rv.push_back(!w1); e_rd.push_back(mm[a1]);
                    if (w1) mm[a1] = d1;
                end
            end
            serve(c0, c1, w0, a0, d0, w1, a1, d1, 20);
            n_tests++;
            if (ev_who.size() !== e_who.size() || v_both !== 0 || v_proto !== 0) begin
                n_fail++; $display("FAIL rand%0d_count: grants %0d both %0d proto %0d want %0d 0 0",
                                   it, ev_who.size(), v_both, v_proto, e_who.size());
            end
            for (int j = 0; j < e_who.size() && j < ev_who.size(); j++) begin
                n_tests++;
                if (ev_who[j] !== e_who[j] || ev_rv[j] !== e_rv[j] || (e_rv[j] && ev_rd[j] !== e_rd[j])) begin
                    n_fail++; $display("FAIL rand%0d_xfer%0d: who %0d rv %b data %h want %0d %b %h",
                                       it, j, ev_who[j], ev_rv[j], ev_rd[j], e_who[j], e_rv[j], e_rd[j]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ifa.req0 = 1'b0; ifa.we0 = 1'b0; ifa.adr0 = '0; ifa.wdata0 = '0;
        ifa.req1 = 1'b0; ifa.we1 = 1'b0; ifa.adr1 = '0; ifa.wdata1 = '0;
        ifb.req0 = 1'b0; ifb.we0 = 1'b0; ifb.adr0 = '0; ifb.wdata0 = '0;
        ifb.req1 = 1'b0; ifb.we1 = 1'b0; ifb.adr1 = '0; ifb.wdata1 = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_reset_mid();
        test_boundary();
        test_rdlat3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
